// File: rtl/wb_writeback_unit_if.sv
// Bus bundle between the MEM stage / register file and the writeback stage.
// The master side drives the instruction and memory inputs; the slave side is the writeback unit.
interface wb_writeback_unit_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        wb_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_we;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;
    logic [PC_W-1:0]   wb_pc;
    logic [DATA_W-1:0] wb_ih;
    logic              wb_valid;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mem_timeout;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output flush, in_valid, wb_sel, rd_addr, rd_we, alu_data, mem_data, mem_ack, wb_pc, wb_ih,
        input  in_ready, wb_valid, wb_we, wb_addr, wb_data, mem_timeout, retire_cnt
    );

    modport slave (
        input  flush, in_valid, wb_sel, rd_addr, rd_we, alu_data, mem_data, mem_ack, wb_pc, wb_ih,
        output in_ready, wb_valid, wb_we, wb_addr, wb_data, mem_timeout, retire_cnt
    );
endinterface

// File: rtl/wb_writeback_unit.sv
// Registered writeback stage: picks ALU/MEM/PC/IH result and presents it to the regfile
// write port, waiting (with optional timeout) for late memory data.
module wb_writeback_unit #(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 16,
    parameter int ADDR_W      = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    wb_writeback_unit_if.slave  io_bus
);
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT_MEM = 1'b1;
    localparam int         TO_W       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [2:0] SEL_ALU = 3'd0;
    localparam logic [2:0] SEL_MEM = 3'd1;
    localparam logic [2:0] SEL_PC  = 3'd2;
    localparam logic [2:0] SEL_IH  = 3'd3;

    logic [0:0]        r_state;
    logic              r_pend_we;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_wb_valid;
    logic              r_wb_we;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_retire;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_nop;
    logic              w_to_hit;
    logic [DATA_W-1:0] w_pc_ext;
    logic [DATA_W-1:0] w_sel_data;

    generate
        if (DATA_W > PC_W) begin : g_pc_zext
            assign w_pc_ext = {{(DATA_W-PC_W){1'b0}}, io_bus.wb_pc};
        end else begin : g_pc_trunc
            assign w_pc_ext = io_bus.wb_pc[DATA_W-1:0];
        end
    endgenerate

    assign w_in_ready = (r_state == S_IDLE);
    assign w_accept   = io_bus.in_valid & w_in_ready & ~io_bus.flush;
    assign w_is_nop   = (io_bus.wb_sel > SEL_IH);
    // The counter value seen here is the number of earlier no-ack WAIT_MEM cycles.
    assign w_to_hit   = (MEM_TIMEOUT != 0) && (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_sel_data = io_bus.alu_data;
        case (io_bus.wb_sel)
            SEL_ALU: w_sel_data = io_bus.alu_data;
            SEL_MEM: w_sel_data = io_bus.mem_data;
            SEL_PC:  w_sel_data = w_pc_ext;
            SEL_IH:  w_sel_data = io_bus.wb_ih;
            default: w_sel_data = io_bus.alu_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pend_we   <= 1'b0;
            r_pend_addr <= '0;
            r_to_cnt    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_timeout   <= 1'b0;
            r_retire    <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_timeout  <= 1'b0;
            if (r_wb_valid && r_wb_we) begin
                r_retire <= r_retire + 1'b1;
            end
            // Flush beats everything, including a pending memory op and a due timeout.
            if (io_bus.flush) begin
                r_state <= S_IDLE;
            end else if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (w_is_nop) begin
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= io_bus.rd_addr;
                    end else if (io_bus.wb_sel == SEL_MEM && !io_bus.mem_ack) begin
                        r_pend_we   <= io_bus.rd_we;
                        r_pend_addr <= io_bus.rd_addr;
                        r_to_cnt    <= '0;
                        r_state     <= S_WAIT_MEM;
                    end else begin
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= io_bus.rd_we;
                        r_wb_addr  <= io_bus.rd_addr;
                        r_wb_data  <= w_sel_data;
                    end
                end
            end else begin
                if (io_bus.mem_ack) begin
                    r_wb_valid <= 1'b1;
                    r_wb_we    <= r_pend_we;
                    r_wb_addr  <= r_pend_addr;
                    r_wb_data  <= io_bus.mem_data;
                    r_state    <= S_IDLE;
                end else if (w_to_hit) begin
                    r_timeout <= 1'b1;
                    r_state   <= S_IDLE;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign io_bus.in_ready    = w_in_ready;
    assign io_bus.wb_valid    = r_wb_valid;
    assign io_bus.wb_we       = r_wb_we;
    assign io_bus.wb_addr     = r_wb_addr;
    assign io_bus.wb_data     = r_wb_data;
    assign io_bus.mem_timeout = r_timeout;
    assign io_bus.retire_cnt  = r_retire;
endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit: each step drives one cycle, queues the expected
// registered result, and compares it one edge later.
module tb_wb_writeback_unit;
    logic clk;
    logic rst_n;

    wb_writeback_unit_if #(.DATA_W(16), .PC_W(16), .ADDR_W(4), .CNT_W(4)) intf ();

    wb_writeback_unit #(
        .DATA_W(16), .PC_W(16), .ADDR_W(4), .CNT_W(4), .MEM_TIMEOUT(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (intf.slave)
    );

    typedef struct {
        string       tag;
        logic        valid;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        tmo;
    } exp_t;

    exp_t       scoreQ[$];
    int         nChecks = 0;
    int         nErrors = 0;
    logic [3:0] mRetire = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (scoreQ.size() == 0) begin
            checkVal("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = scoreQ.pop_front();
        checkVal({e.tag, ".valid"}, {31'd0, intf.wb_valid}, {31'd0, e.valid});
        checkVal({e.tag, ".we"}, {31'd0, intf.wb_we}, {31'd0, e.we});
        checkVal({e.tag, ".addr"}, {28'd0, intf.wb_addr}, {28'd0, e.addr});
        checkVal({e.tag, ".data"}, {16'd0, intf.wb_data}, {16'd0, e.data});
        checkVal({e.tag, ".timeout"}, {31'd0, intf.mem_timeout}, {31'd0, e.tmo});
        checkVal({e.tag, ".retire"}, {28'd0, intf.retire_cnt}, {28'd0, mRetire});
        if (e.valid && e.we) mRetire = mRetire + 4'd1;
    endtask

    task automatic applyStimulus(
        input string tag,
        input logic v, input logic [2:0] sel, input logic [3:0] rd, input logic we,
        input logic [15:0] alu, input logic [15:0] memd, input logic ack, input logic fl,
        input logic expRdy, input logic expV, input logic expWe,
        input logic [3:0] expA, input logic [15:0] expD, input logic expT
    );
        exp_t e;
        intf.in_valid = v;
        intf.wb_sel   = sel;
        intf.rd_addr  = rd;
        intf.rd_we    = we;
        intf.alu_data = alu;
        intf.mem_data = memd;
        intf.mem_ack  = ack;
        intf.flush    = fl;
        #1;
        checkVal({tag, ".in_ready"}, {31'd0, intf.in_ready}, {31'd0, expRdy});
        e.tag = tag; e.valid = expV; e.we = expWe; e.addr = expA; e.data = expD; e.tmo = expT;
        scoreQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, ".valid"}, {31'd0, intf.wb_valid}, 32'd0);
        checkVal({tag, ".we"}, {31'd0, intf.wb_we}, 32'd0);
        checkVal({tag, ".addr"}, {28'd0, intf.wb_addr}, 32'd0);
        checkVal({tag, ".data"}, {16'd0, intf.wb_data}, 32'd0);
        checkVal({tag, ".timeout"}, {31'd0, intf.mem_timeout}, 32'd0);
        checkVal({tag, ".retire"}, {28'd0, intf.retire_cnt}, 32'd0);
        checkVal({tag, ".in_ready"}, {31'd0, intf.in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        intf.flush = 1'b0; intf.in_valid = 1'b0; intf.wb_sel = 3'd4; intf.rd_addr = '0;
        intf.rd_we = 1'b0; intf.alu_data = '0; intf.mem_data = '0; intf.mem_ack = 1'b0;
        intf.wb_pc = 16'hC0DE; intf.wb_ih = 16'h5A5A;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;
        mRetire = '0;

        // Single-cycle sources
        applyStimulus("alu",     1, 3'd0, 4'd3, 1, 16'h1234, 16'h0000, 0, 0, 1, 1, 1, 4'd3, 16'h1234, 0);
        applyStimulus("idle1",   0, 3'd0, 4'd0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4'd3, 16'h1234, 0);
        applyStimulus("pc",      1, 3'd2, 4'd5, 1, 16'h0000, 16'h0000, 0, 0, 1, 1, 1, 4'd5, 16'hC0DE, 0);
        applyStimulus("ih_nowe", 1, 3'd3, 4'd6, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 4'd6, 16'h5A5A, 0);
        applyStimulus("mem_ack", 1, 3'd1, 4'd7, 1, 16'h0000, 16'h1111, 1, 0, 1, 1, 1, 4'd7, 16'h1111, 0);

        // NOP variants keep the last data
        applyStimulus("alu_aa",  1, 3'd0, 4'd2, 1, 16'hAAAA, 16'h0000, 0, 0, 1, 1, 1, 4'd2, 16'hAAAA, 0);
        applyStimulus("nop4",    1, 3'd4, 4'd9, 1, 16'h5555, 16'h0000, 0, 0, 1, 1, 0, 4'd9, 16'hAAAA, 0);
        applyStimulus("nop7",    1, 3'd7, 4'hA, 1, 16'h5555, 16'h0000, 0, 0, 1, 1, 0, 4'hA, 16'hAAAA, 0);

        // Memory wait: three cycles without ack, ack on the last allowed cycle
        applyStimulus("mw_go",   1, 3'd1, 4'd4, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4'hA, 16'hAAAA, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("mw_wait", 1, 3'd1, 4'd4, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 4'hA, 16'hAAAA, 0);
        applyStimulus("mw_ack",  1, 3'd1, 4'd4, 1, 16'h0000, 16'hBEEF, 1, 0, 0, 1, 1, 4'd4, 16'hBEEF, 0);
        applyStimulus("mw_done", 0, 3'd0, 4'd0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4'd4, 16'hBEEF, 0);

        // Timeout after four WAIT_MEM cycles, then a stray ack in IDLE
        applyStimulus("to_go",   1, 3'd1, 4'd8, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4'd4, 16'hBEEF, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("to_wait", 0, 3'd1, 4'd8, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 4'd4, 16'hBEEF, 0);
        applyStimulus("to_fire", 0, 3'd1, 4'd8, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 4'd4, 16'hBEEF, 1);
        applyStimulus("to_idle", 0, 3'd0, 4'd0, 0, 16'h0000, 16'h7777, 1, 0, 1, 0, 0, 4'd4, 16'hBEEF, 0);

        // Flush while waiting, then a late ack must be ignored
        applyStimulus("fl_go",   1, 3'd1, 4'hB, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4'd4, 16'hBEEF, 0);
        applyStimulus("fl_hit",  0, 3'd1, 4'hB, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 4'd4, 16'hBEEF, 0);
        applyStimulus("fl_late", 0, 3'd0, 4'd0, 0, 16'h0000, 16'hDEAD, 1, 0, 1, 0, 0, 4'd4, 16'hBEEF, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus("fl_quiet", 0, 3'd0, 4'd0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4'd4, 16'hBEEF, 0);
        applyStimulus("fl_drop", 1, 3'd0, 4'hC, 1, 16'h7777, 16'h0000, 0, 1, 1, 0, 0, 4'd4, 16'hBEEF, 0);

        // Asynchronous reset in the middle of a memory wait
        applyStimulus("rs_go",   1, 3'd1, 4'hC, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4'd4, 16'hBEEF, 0);
        applyStimulus("rs_wait", 0, 3'd1, 4'hC, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 4'd4, 16'hBEEF, 0);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetState("async_reset");
        #1;
        rst_n = 1'b1;
        mRetire = '0;
        @(posedge clk);
        #1;

        // Seventeen writes wrap the 4-bit retire counter to 1
        for (int i = 0; i < 17; i++)
            applyStimulus("wrap_wr", 1, 3'd0, 4'(i), 1, 16'h0100 + 16'(i), 16'h0000, 0, 0,
                          1, 1, 1, 4'(i), 16'h0100 + 16'(i), 0);
        applyStimulus("wrap_end", 0, 3'd0, 4'd0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4'd0, 16'h0110, 0);
        checkVal("wrap_retire", {28'd0, intf.retire_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
